// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR address map, funct3 op encodings and mcountinhibit bit indices
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_TIME          = 12'hC01;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_TIMEH         = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

  typedef enum logic [2:0] {
    OP_NONE0 = 3'b000,
    OP_RW    = 3'b001,
    OP_RS    = 3'b010,
    OP_RC    = 3'b011,
    OP_NONE4 = 3'b100,
    OP_RWI   = 3'b101,
    OP_RSI   = 3'b110,
    OP_RCI   = 3'b111
  } csr_op_e;

  localparam int MCI_CY = 0;
  localparam int MCI_IR = 2;
  localparam logic [31:0] MCI_MASK = 32'h0000_0005;

  // User-mode counter shadows: readable, never writable.
  function automatic logic is_ro_counter(input logic [11:0] addr);
    return (addr == CSR_CYCLE)  || (addr == CSR_TIME)  || (addr == CSR_INSTRET) ||
           (addr == CSR_CYCLEH) || (addr == CSR_TIMEH) || (addr == CSR_INSTRETH);
  endfunction

endpackage

// File: rtl/csr_wdata_alu.sv
// rtl/csr_wdata_alu.sv - combinational CSR write-value ALU (RW/RS/RC and immediate forms)
module csr_wdata_alu
  import csr_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [4:0]  i_zimm,
  input  logic [31:0] i_old,
  output logic [31:0] o_new,
  output logic        o_do_write
);

  logic [31:0] w_src;
  logic        w_zimm_nz;

  assign w_src     = i_op[2] ? {27'b0, i_zimm} : i_rs1;
  assign w_zimm_nz = (i_zimm != 5'd0);

  // Set/clear with a zero rs1 index is a pure read and must not count as a write.
  always_comb begin
    o_new      = i_old;
    o_do_write = 1'b0;
    case (i_op)
      OP_RW, OP_RWI: begin
        o_new      = w_src;
        o_do_write = 1'b1;
      end
      OP_RS, OP_RSI: begin
        o_new      = i_old | w_src;
        o_do_write = w_zimm_nz;
      end
      OP_RC, OP_RCI: begin
        o_new      = i_old & ~w_src;
        o_do_write = w_zimm_nz;
      end
      default: begin
        o_new      = i_old;
        o_do_write = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_counter_write_unit.sv
// rtl/csr_counter_write_unit.sv - owns mcycle/minstret/mscratch/mcountinhibit and decodes CSR writes
module csr_counter_write_unit
  import csr_pkg::*;
#(
  parameter logic [63:0] MCYCLE_RST   = 64'h0,
  parameter logic [63:0] MINSTRET_RST = 64'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        csr_wr_en_in,
  input  logic [11:0] csr_addr_in,
  input  logic [2:0]  csr_op_in,
  input  logic [31:0] rs1_data_in,
  input  logic [4:0]  rs1_zimm_in,
  input  logic        instret_inc_in,
  output logic [63:0] mcycle_out,
  output logic [63:0] minstret_out,
  output logic [31:0] mscratch_out,
  output logic [31:0] mcountinhibit_out,
  output logic        illegal_wr_out
);

  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
  logic [31:0] r_mscratch;
  logic [31:0] r_mcountinhibit;
  logic        r_illegal;

  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_do_write;
  logic        w_wr;

  always_comb begin
    w_old = 32'h0;
    case (csr_addr_in)
      CSR_MSCRATCH:      w_old = r_mscratch;
      CSR_MCOUNTINHIBIT: w_old = r_mcountinhibit;
      CSR_MCYCLE:        w_old = r_mcycle[31:0];
      CSR_MCYCLEH:       w_old = r_mcycle[63:32];
      CSR_MINSTRET:      w_old = r_minstret[31:0];
      CSR_MINSTRETH:     w_old = r_minstret[63:32];
      default:           w_old = 32'h0;
    endcase
  end

  csr_wdata_alu u_alu (
    .i_op       (csr_op_in),
    .i_rs1      (rs1_data_in),
    .i_zimm     (rs1_zimm_in),
    .i_old      (w_old),
    .o_new      (w_new),
    .o_do_write (w_do_write)
  );

  assign w_wr = csr_wr_en_in & w_do_write;

  // A software write to either half owns the counter for that cycle; no increment, no carry.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_mcycle        <= MCYCLE_RST;
      r_minstret      <= MINSTRET_RST;
      r_mscratch      <= 32'h0;
      r_mcountinhibit <= 32'h0;
      r_illegal       <= 1'b0;
    end else begin
      if (w_wr && csr_addr_in == CSR_MCYCLE)
        r_mcycle <= {r_mcycle[63:32], w_new};
      else if (w_wr && csr_addr_in == CSR_MCYCLEH)
        r_mcycle <= {w_new, r_mcycle[31:0]};
      else if (!r_mcountinhibit[MCI_CY])
        r_mcycle <= r_mcycle + 64'd1;

      if (w_wr && csr_addr_in == CSR_MINSTRET)
        r_minstret <= {r_minstret[63:32], w_new};
      else if (w_wr && csr_addr_in == CSR_MINSTRETH)
        r_minstret <= {w_new, r_minstret[31:0]};
      else if (instret_inc_in && !r_mcountinhibit[MCI_IR])
        r_minstret <= r_minstret + 64'd1;

      if (w_wr && csr_addr_in == CSR_MSCRATCH)
        r_mscratch <= w_new;
      if (w_wr && csr_addr_in == CSR_MCOUNTINHIBIT)
        r_mcountinhibit <= w_new & MCI_MASK;

      r_illegal <= w_wr && is_ro_counter(csr_addr_in);
    end
  end

  assign mcycle_out        = r_mcycle;
  assign minstret_out      = r_minstret;
  assign mscratch_out      = r_mscratch;
  assign mcountinhibit_out = r_mcountinhibit;
  assign illegal_wr_out    = r_illegal;

endmodule

// File: tb/tb_csr_counter_write_unit.sv
// tb/tb_csr_counter_write_unit.sv - self-checking bench for csr_counter_write_unit
module tb_csr_counter_write_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        csr_wr_en_in;
  logic [11:0] csr_addr_in;
  logic [2:0]  csr_op_in;
  logic [31:0] rs1_data_in;
  logic [4:0]  rs1_zimm_in;
  logic        instret_inc_in;
  logic [63:0] mcycle_out;
  logic [63:0] minstret_out;
  logic [31:0] mscratch_out;
  logic [31:0] mcountinhibit_out;
  logic        illegal_wr_out;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_cycle, m_instret;
  logic [31:0] m_scratch, m_inhibit;
  logic        m_illegal;

  csr_counter_write_unit dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .csr_wr_en_in      (csr_wr_en_in),
    .csr_addr_in       (csr_addr_in),
    .csr_op_in         (csr_op_in),
    .rs1_data_in       (rs1_data_in),
    .rs1_zimm_in       (rs1_zimm_in),
    .instret_inc_in    (instret_inc_in),
    .mcycle_out        (mcycle_out),
    .minstret_out      (minstret_out),
    .mscratch_out      (mscratch_out),
    .mcountinhibit_out (mcountinhibit_out),
    .illegal_wr_out    (illegal_wr_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_reset();
    m_cycle = 64'h0; m_instret = 64'h0; m_scratch = 32'h0; m_inhibit = 32'h0; m_illegal = 1'b0;
  endtask

  // Reference: what the architectural state should be after the coming edge.
  task automatic model_edge();
    logic [31:0] src, oldv, newv;
    logic        wr;
    logic [63:0] nc, ni;
    logic [31:0] ns, nh;
    logic        nl;
    src  = csr_op_in[2] ? {27'b0, rs1_zimm_in} : rs1_data_in;
    oldv = 32'h0;
    if (csr_addr_in == 12'h340) oldv = m_scratch;
    if (csr_addr_in == 12'h320) oldv = m_inhibit;
    if (csr_addr_in == 12'hB00) oldv = m_cycle[31:0];
    if (csr_addr_in == 12'hB80) oldv = m_cycle[63:32];
    if (csr_addr_in == 12'hB02) oldv = m_instret[31:0];
    if (csr_addr_in == 12'hB82) oldv = m_instret[63:32];
    wr = 1'b0; newv = oldv;
    if (csr_wr_en_in) begin
      if (csr_op_in == 3'd1 || csr_op_in == 3'd5) begin wr = 1'b1; newv = src; end
      if (csr_op_in == 3'd2 || csr_op_in == 3'd6) begin wr = (rs1_zimm_in != 0); newv = oldv | src; end
      if (csr_op_in == 3'd3 || csr_op_in == 3'd7) begin wr = (rs1_zimm_in != 0); newv = oldv & ~src; end
    end
    nc = (m_inhibit[0] == 1'b0) ? m_cycle + 64'd1 : m_cycle;
    ni = (instret_inc_in && m_inhibit[2] == 1'b0) ? m_instret + 64'd1 : m_instret;
    ns = m_scratch; nh = m_inhibit; nl = 1'b0;
    if (wr) begin
      case (csr_addr_in)
        12'h340: ns = newv;
        12'h320: nh = newv & 32'h5;
        12'hB00: nc = (m_cycle & 64'hFFFF_FFFF_0000_0000) | {32'h0, newv};
        12'hB80: nc = (m_cycle & 64'h0000_0000_FFFF_FFFF) | ({32'h0, newv} << 32);
        12'hB02: ni = (m_instret & 64'hFFFF_FFFF_0000_0000) | {32'h0, newv};
        12'hB82: ni = (m_instret & 64'h0000_0000_FFFF_FFFF) | ({32'h0, newv} << 32);
        12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82: nl = 1'b1;
        default: ;
      endcase
    end
    m_cycle = nc; m_instret = ni; m_scratch = ns; m_inhibit = nh; m_illegal = nl;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic en, input logic [11:0] a, input logic [2:0] op,
                       input logic [31:0] rs1, input logic [4:0] z, input logic inc);
    csr_wr_en_in = en; csr_addr_in = a; csr_op_in = op;
    rs1_data_in = rs1; rs1_zimm_in = z; instret_inc_in = inc;
  endtask

  task automatic test_reset();
    drive(1'b0, 12'h0, 3'd0, 32'h0, 5'd0, 1'b0);
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if (mcycle_out !== 64'h0 || minstret_out !== 64'h0 || mscratch_out !== 32'h0 ||
        mcountinhibit_out !== 32'h0 || illegal_wr_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: mcycle=%h minstret=%h mscratch=%h inhibit=%h illegal=%b required all 0",
               mcycle_out, minstret_out, mscratch_out, mcountinhibit_out, illegal_wr_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    for (int i = 0; i < 85; i++) tick();
    checks++;
    if (mcycle_out !== 64'h55) begin
      errors++;
      $display("FAIL count_to_55: mcycle=%h required 55", mcycle_out);
    end
    #2;
    rst_in = 1'b1;
    drive(1'b1, 12'h340, 3'd1, 32'hABCD_0123, 5'd1, 1'b1);
    #1;
    checks++;
    if (mcycle_out !== 64'h0 || minstret_out !== 64'h0 || mscratch_out !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: mcycle=%h minstret=%h mscratch=%h required 0",
               mcycle_out, minstret_out, mscratch_out);
    end
    @(posedge clk_in);
    #1;
    checks++;
    if (mscratch_out !== 32'h0 || mcycle_out !== 64'h0) begin
      errors++;
      $display("FAIL reset_discards_write: mscratch=%h mcycle=%h required 0", mscratch_out, mcycle_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    drive(1'b0, 12'h0, 3'd0, 32'h0, 5'd0, 1'b0);
    model_reset();
    tick();
    checks++;
    if (mcycle_out !== 64'h1 || mscratch_out !== 32'h0) begin
      errors++;
      $display("FAIL release: mcycle=%h mscratch=%h required 1 and 0", mcycle_out, mscratch_out);
    end
  endtask

  task automatic test_carry();
    drive(1'b1, 12'hB00, 3'd1, 32'hFFFF_FFFF, 5'd1, 1'b0); tick();
    drive(1'b1, 12'hB80, 3'd1, 32'h0, 5'd1, 1'b0); tick();
    checks++;
    if (mcycle_out !== 64'h0000_0000_FFFF_FFFF) begin
      errors++;
      $display("FAIL half_write: mcycle=%h required 00000000ffffffff", mcycle_out);
    end
    drive(1'b0, 12'h0, 3'd0, 32'h0, 5'd0, 1'b0); tick();
    checks++;
    if (mcycle_out !== 64'h0000_0001_0000_0000) begin
      errors++;
      $display("FAIL carry: mcycle=%h required 0000000100000000", mcycle_out);
    end
    drive(1'b1, 12'hB80, 3'd1, 32'hFFFF_FFFF, 5'd1, 1'b0); tick();
    drive(1'b1, 12'hB00, 3'd5, 32'h0, 5'd30, 1'b0); tick();
    drive(1'b1, 12'hB00, 3'd2, 32'hFFFF_FFFE, 5'd1, 1'b0); tick();
    drive(1'b0, 12'h0, 3'd0, 32'h0, 5'd0, 1'b0); tick();
    checks++;
    if (mcycle_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL near_wrap: mcycle=%h required ffffffffffffffff", mcycle_out);
    end
    tick();
    checks++;
    if (mcycle_out !== 64'h0) begin
      errors++;
      $display("FAIL wrap: mcycle=%h required 0", mcycle_out);
    end
  endtask

  task automatic test_inhibit();
    logic [63:0] frozen;
    drive(1'b1, 12'h320, 3'd2, 32'h5, 5'd1, 1'b0); tick();
    frozen = m_cycle;
    checks++;
    if (mcountinhibit_out !== 32'h5 || mcycle_out !== frozen) begin
      errors++;
      $display("FAIL inhibit_set: inhibit=%h mcycle=%h required 5 and %h", mcountinhibit_out, mcycle_out, frozen);
    end
    drive(1'b0, 12'h0, 3'd0, 32'h0, 5'd0, 1'b1);
    repeat (3) tick();
    checks++;
    if (mcycle_out !== frozen || minstret_out !== m_instret) begin
      errors++;
      $display("FAIL inhibit_frozen: mcycle=%h minstret=%h required %h %h",
               mcycle_out, minstret_out, frozen, m_instret);
    end
    drive(1'b1, 12'h320, 3'd3, 32'h1, 5'd1, 1'b0); tick();
    checks++;
    if (mcountinhibit_out !== 32'h4 || mcycle_out !== frozen) begin
      errors++;
      $display("FAIL inhibit_clear: inhibit=%h mcycle=%h required 4 and %h", mcountinhibit_out, mcycle_out, frozen);
    end
    drive(1'b0, 12'h0, 3'd0, 32'h0, 5'd0, 1'b0); tick();
    checks++;
    if (mcycle_out !== frozen + 64'd1) begin
      errors++;
      $display("FAIL resume: mcycle=%h required %h", mcycle_out, frozen + 64'd1);
    end
    drive(1'b1, 12'h320, 3'd1, 32'hFFFF_FFFF, 5'd1, 1'b0); tick();
    checks++;
    if (mcountinhibit_out !== 32'h5) begin
      errors++;
      $display("FAIL inhibit_mask: inhibit=%h required 5", mcountinhibit_out);
    end
    drive(1'b1, 12'h320, 3'd5, 32'h0, 5'd0, 1'b0); tick();
  endtask

  task automatic test_scratch();
    drive(1'b1, 12'h340, 3'd1, 32'hDEAD_BEEF, 5'd3, 1'b0); tick();
    checks++;
    if (mscratch_out !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL scratch_rw: mscratch=%h required deadbeef", mscratch_out);
    end
    drive(1'b1, 12'h340, 3'd7, 32'hFFFF_FFFF, 5'd0, 1'b0); tick();
    drive(1'b1, 12'h340, 3'd3, 32'hFFFF_FFFF, 5'd0, 1'b0); tick();
    checks++;
    if (mscratch_out !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL scratch_rc_zero: mscratch=%h required deadbeef", mscratch_out);
    end
    drive(1'b1, 12'h340, 3'd4, 32'h1, 5'd1, 1'b0); tick();
    checks++;
    if (mscratch_out !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL scratch_bad_op: mscratch=%h required deadbeef", mscratch_out);
    end
    drive(1'b1, 12'h340, 3'd5, 32'hFFFF_FFFF, 5'd0, 1'b0); tick();
    checks++;
    if (mscratch_out !== 32'h0) begin
      errors++;
      $display("FAIL scratch_rwi_zero: mscratch=%h required 0", mscratch_out);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 12'hC00, 3'd1, 32'h1234, 5'd1, 1'b0); tick();
    checks++;
    if (illegal_wr_out !== 1'b1 || mcycle_out !== m_cycle) begin
      errors++;
      $display("FAIL illegal_pulse: illegal=%b mcycle=%h required 1 and %h", illegal_wr_out, mcycle_out, m_cycle);
    end
    drive(1'b0, 12'hC00, 3'd1, 32'h1234, 5'd1, 1'b0); tick();
    checks++;
    if (illegal_wr_out !== 1'b0) begin
      errors++;
      $display("FAIL illegal_one_cycle: illegal=%b required 0", illegal_wr_out);
    end
    drive(1'b1, 12'hC00, 3'd2, 32'h0, 5'd0, 1'b0); tick();
    checks++;
    if (illegal_wr_out !== 1'b0) begin
      errors++;
      $display("FAIL illegal_rs_zero: illegal=%b required 0", illegal_wr_out);
    end
    drive(1'b1, 12'hC82, 3'd6, 32'h0, 5'd4, 1'b0); tick();
    checks++;
    if (illegal_wr_out !== 1'b1) begin
      errors++;
      $display("FAIL illegal_c82: illegal=%b required 1", illegal_wr_out);
    end
  endtask

  task automatic test_minstret();
    drive(1'b1, 12'hB82, 3'd1, 32'h77, 5'd1, 1'b0); tick();
    drive(1'b1, 12'hB02, 3'd1, 32'h10, 5'd1, 1'b1); tick();
    checks++;
    if (minstret_out !== 64'h0000_0077_0000_0010) begin
      errors++;
      $display("FAIL minstret_write_wins: minstret=%h required 0000007700000010", minstret_out);
    end
    drive(1'b0, 12'h0, 3'd0, 32'h0, 5'd0, 1'b1); tick();
    checks++;
    if (minstret_out !== 64'h0000_0077_0000_0011) begin
      errors++;
      $display("FAIL minstret_inc: minstret=%h required 0000007700000011", minstret_out);
    end
  endtask

  task automatic test_random();
    logic [11:0] addrs [14];
    logic [31:0] rs1;
    addrs = '{12'h340, 12'h320, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
              12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82, 12'h300, 12'hB03};
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: rs1 = 32'hFFFF_FFFF;
        1: rs1 = 32'h0;
        default: rs1 = $urandom;
      endcase
      drive($urandom_range(0, 1) == 1, addrs[$urandom_range(0, 13)], 3'($urandom_range(0, 7)), rs1,
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom_range(0, 1) == 1);
      tick();
      checks++;
      if (mcycle_out !== m_cycle || minstret_out !== m_instret || mscratch_out !== m_scratch ||
          mcountinhibit_out !== m_inhibit || illegal_wr_out !== m_illegal) begin
        errors++;
        $display("FAIL random[%0d]: got %h %h %h %h %b required %h %h %h %h %b", i,
                 mcycle_out, minstret_out, mscratch_out, mcountinhibit_out, illegal_wr_out,
                 m_cycle, m_instret, m_scratch, m_inhibit, m_illegal);
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_inhibit();
    test_scratch();
    test_illegal();
    test_minstret();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
